fp16_cmp_ctrl: RTL and testbench
================================

// Module: fp16_cmp_ctrl
// PURPOSE
//  Multi-cycle FP16 (1/5/10) magnitude+sign comparator controller. Shares ONE 16-bit CLA
//  subtractor between the exponent compare and the mantissa compare, sequenced by an FSM.
//  Sits in front of the FP16 adder path: decides operand order (swap) and flags equality/NaN.
//  Valid/ready in, valid/ready out; one comparison in flight at a time.
// PARAMETERS
//  EXP_W      5   exponent field width
//  MAN_W      10  mantissa field width (hidden bit not stored)
//  EARLY_EXIT 1   1: skip MAN cycle when exponents differ or a special case resolves; 0: always run MAN
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous reset, active low
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   controller idle, can accept
//  a          in   16  FP16 operand A
//  b          in   16  FP16 operand B
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  a_big      out  1   A > B (signed FP order)
//  b_big      out  1   B > A
//  equal      out  1   A == B (+0 == -0)
//  unordered  out  1   either operand NaN (exp all-ones, man != 0); a_big/b_big/equal = 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, in_ready=1, out_valid=0, all flags 0, operand regs 0.
//  States: IDLE -> EXP -> (MAN) -> RES -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready latches a,b; next EXP. Otherwise stay.
//   EXP : shared sub computes {11'b0,expA} + ~{11'b0,expB} + 1. Special decode same cycle:
//         NaN -> unordered; both zero (exp=0,man=0) -> equal; signs differ -> positive operand big.
//         Special, or exp diff != 0 with EARLY_EXIT=1 -> RES. Else -> MAN.
//   MAN : shared sub computes {6'b0,manA} + ~{6'b0,manB} + 1; result==0 -> mag equal,
//         bit[MAN_W] (borrow) set -> |B|>|A|, else |A|>|B|. -> RES.
//   RES : out_valid=1, flags stable. out_ready -> IDLE (in_ready=1 next cycle). Else hold.
//  Magnitude->order: both positive: bigger magnitude wins; both negative: result inverted.
//  Exactly one of a_big/b_big/equal/unordered is 1 whenever out_valid=1; all 0 otherwise.
//  Infinity needs no special case (exp=31,man=0 compares as largest magnitude).
//  Denormals compare correctly by raw fields (exp=0); no normalisation.
//  Latency (accept edge to out_valid): 2 cycles early-exit, 3 cycles via MAN.
//  No accept while busy: in_ready=0 in EXP/MAN/RES; in_valid there is ignored, not queued.
//  Reset mid-operation aborts; no partial result ever appears on outputs.
//  Sub operand mux select is registered state only (no combinational loop from in_valid).
// STRUCTURE
//  Shared package fp16_pkg: EXP_W/MAN_W/field slice constants, EXP_MAX, FSM state encoding
//   (IDLE=2'd0, EXP=2'd1, MAN=2'd2, RES=2'd3), is_nan/is_zero helper functions.
//  One sub-module: fp16_sub16 - 16-bit x + ~y + 1 built on existing CLA, outputs diff and
//   zero flag; the only arithmetic instance in the block, input muxed by state.
//  Controller = FSM + operand regs + result flag regs.
// TESTING
//  a=0x3C00(1.0), b=0x4000(2.0) -> b_big=1, out_valid 2 cycles after accept (early exit).
//  a=0x3C01, b=0x3C00 -> a_big=1 via MAN, latency 3; with EARLY_EXIT=0 case 1 also latency 3.
//  a=0x8000(-0), b=0x0000(+0) -> equal=1; a=0xC000(-2), b=0xBC00(-1) -> b_big=1.
//  a=0x7E00(NaN), b=0x3C00 -> unordered=1, others 0; a=0x7C00(+inf), b=0x7BFF -> a_big=1.
//  Backpressure: out_ready=0 for 5 cycles -> out_valid and flags held, in_ready=0; new
//   in_valid pulse during hold ignored; out_ready=1 -> in_ready=1 next cycle.
//  rst_n=0 during MAN -> next cycle out_valid=0, in_ready=1, flags 0; back-to-back pairs
//   after reset compare correctly.

Source files
------------

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 comparator constants, FSM encoding and field helpers
package fp16_pkg;

   localparam int EXP_W    = 5;
   localparam int MAN_W    = 10;
   localparam int FP_W     = 1 + EXP_W + MAN_W;
   localparam int SUB_W    = 16;
   localparam int MAN_LSB  = 0;
   localparam int EXP_LSB  = MAN_W;
   localparam int SIGN_BIT = FP_W - 1;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   // Result flag vector layout: {unordered, equal, b_big, a_big}
   localparam logic [3:0] FLAG_NONE  = 4'b0000;
   localparam logic [3:0] FLAG_A_BIG = 4'b0001;
   localparam logic [3:0] FLAG_B_BIG = 4'b0010;
   localparam logic [3:0] FLAG_EQ    = 4'b0100;
   localparam logic [3:0] FLAG_UNORD = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXP  = 2'd1,
      ST_MAN  = 2'd2,
      ST_RES  = 2'd3
   } state_e;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return (x[EXP_LSB +: EXP_W] == EXP_MAX) && (x[MAN_LSB +: MAN_W] != '0);
   endfunction

   function automatic logic is_zero(input logic [FP_W-1:0] x);
      return x[SIGN_BIT-1:0] == '0;
   endfunction

   // Turns a magnitude ordering into signed order for two operands sharing sign neg.
   function automatic logic [3:0] order_flags(input logic gt, input logic lt, input logic neg);
      if (gt) return neg ? FLAG_B_BIG : FLAG_A_BIG;
      if (lt) return neg ? FLAG_A_BIG : FLAG_B_BIG;
      return FLAG_EQ;
   endfunction

endpackage

// File: rtl/fp16_sub16.sv
// rtl/fp16_sub16.sv - 16-bit x + ~y + 1 on a two-level carry-lookahead adder
module fp16_sub16
   import fp16_pkg::*;
(
   input  logic [SUB_W-1:0] x_i,
   input  logic [SUB_W-1:0] y_i,
   output logic [SUB_W-1:0] diff_o,
   output logic             zero_o
);

   localparam int GRP_W = 4;
   localparam int N_GRP = SUB_W / GRP_W;

   logic [SUB_W-1:0] g, p, c;
   logic [N_GRP-2:0] gg, gp;
   logic [N_GRP-1:0] gc;
   logic             carry;

   assign g = x_i & ~y_i;
   assign p = x_i ^ ~y_i;

   // Group generate/propagate feed the group carries; bit carries ripple only inside a group.
   always_comb begin
      gg    = '0;
      gp    = '0;
      gc    = '0;
      c     = '0;
      carry = 1'b0;
      for (int k = 0; k < N_GRP - 1; k++) begin
         gp[k] = 1'b1;
         for (int j = 0; j < GRP_W; j++) begin
            gg[k] = g[k*GRP_W+j] | (p[k*GRP_W+j] & gg[k]);
            gp[k] = gp[k] & p[k*GRP_W+j];
         end
      end
      gc[0] = 1'b1;
      for (int k = 0; k < N_GRP - 1; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < N_GRP; k++) begin
         carry = gc[k];
         for (int j = 0; j < GRP_W; j++) begin
            c[k*GRP_W+j] = carry;
            carry        = g[k*GRP_W+j] | (p[k*GRP_W+j] & carry);
         end
      end
   end

   assign diff_o = p ^ c;
   assign zero_o = (diff_o == '0);

endmodule

// File: rtl/fp16_cmp_ctrl.sv
// rtl/fp16_cmp_ctrl.sv - multi-cycle FP16 comparator sharing one subtractor for exponent and mantissa
module fp16_cmp_ctrl
   import fp16_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            a_big,
   output logic            b_big,
   output logic            equal,
   output logic            unordered
);

   state_e            state_q, state_d;
   logic [FP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [3:0]        flags_q, flags_d;
   logic              done_q, done_d;

   logic [SUB_W-1:0]  sub_x, sub_y, sub_diff;
   logic              sub_zero, mag_lt, mag_gt;

   // Operand select depends on registered state only.
   always_comb begin
      sub_x = {{(SUB_W-EXP_W){1'b0}}, a_q[EXP_LSB +: EXP_W]};
      sub_y = {{(SUB_W-EXP_W){1'b0}}, b_q[EXP_LSB +: EXP_W]};
      if (state_q == ST_MAN) begin
         sub_x = {{(SUB_W-MAN_W){1'b0}}, a_q[MAN_LSB +: MAN_W]};
         sub_y = {{(SUB_W-MAN_W){1'b0}}, b_q[MAN_LSB +: MAN_W]};
      end
   end

   fp16_sub16 u_sub (
      .x_i    (sub_x),
      .y_i    (sub_y),
      .diff_o (sub_diff),
      .zero_o (sub_zero)
   );

   // Zero-extended operands: every bit from the field width up mirrors the borrow.
   assign mag_lt = sub_diff[SUB_W-1];
   assign mag_gt = !mag_lt && (sub_diff[SUB_W-2:0] != '0);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      flags_d = flags_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               flags_d = FLAG_NONE;
               done_d  = 1'b0;
               state_d = ST_EXP;
            end
         end
         ST_EXP: begin
            done_d = 1'b1;
            if (is_nan(a_q) || is_nan(b_q))          flags_d = FLAG_UNORD;
            else if (is_zero(a_q) && is_zero(b_q))   flags_d = FLAG_EQ;
            else if (a_q[SIGN_BIT] != b_q[SIGN_BIT]) flags_d = a_q[SIGN_BIT] ? FLAG_B_BIG : FLAG_A_BIG;
            else if (!sub_zero)                      flags_d = order_flags(mag_gt, mag_lt, a_q[SIGN_BIT]);
            else                                     done_d  = 1'b0;
            state_d = (done_d && EARLY_EXIT) ? ST_RES : ST_MAN;
         end
         ST_MAN: begin
            if (!done_q) flags_d = order_flags(mag_gt, mag_lt, a_q[SIGN_BIT]);
            done_d  = 1'b1;
            state_d = ST_RES;
         end
         ST_RES: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         flags_q <= FLAG_NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_RES);
   assign {unordered, equal, b_big, a_big} = out_valid ? flags_q : FLAG_NONE;

endmodule

// File: tb/tb_fp16_cmp_ctrl.sv
// tb/tb_fp16_cmp_ctrl.sv - randomized self-checking bench for fp16_cmp_ctrl (both EARLY_EXIT settings)
module tb_fp16_cmp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;

   logic in_ready, out_valid, a_big, b_big, equal, unordered;
   logic in_ready0, out_valid0, a_big0, b_big0, equal0, unordered0;

   int n_checks = 0;
   int n_errors = 0;

   fp16_cmp_ctrl #(.EARLY_EXIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .a_big(a_big), .b_big(b_big), .equal(equal), .unordered(unordered)
   );

   fp16_cmp_ctrl #(.EARLY_EXIT(1'b0)) dut_full (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
      .a_big(a_big0), .b_big(b_big0), .equal(equal0), .unordered(unordered0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit ref_nan(input logic [15:0] x);
      return (int'(x[14:10]) == 31) && (int'(x[9:0]) != 0);
   endfunction

   // Signed value on an integer scale: exponent*1024+mantissa is monotonic in |x|.
   function automatic int ref_value(input logic [15:0] x);
      int mag;
      mag = int'(x[14:10]) * 1024 + int'(x[9:0]);
      return x[15] ? -mag : mag;
   endfunction

   // {unordered, equal, b_big, a_big}
   function automatic logic [3:0] ref_flags(input logic [15:0] x, input logic [15:0] y);
      int vx, vy;
      if (ref_nan(x) || ref_nan(y)) return 4'b1000;
      vx = ref_value(x);
      vy = ref_value(y);
      if (vx == vy) return 4'b0100;
      if (vx > vy)  return 4'b0001;
      return 4'b0010;
   endfunction

   function automatic int ref_latency(input logic [15:0] x, input logic [15:0] y);
      if (ref_nan(x) || ref_nan(y))              return 2;
      if (x[14:0] == 15'd0 && y[14:0] == 15'd0)  return 2;
      if (x[15] != y[15])                        return 2;
      if (x[14:10] != y[14:10])                  return 2;
      return 3;
   endfunction

   task automatic run_pair(input logic [15:0] xa, input logic [15:0] xb, input int hold,
                           input bit pulse, input string tag);
      int         lat1, lat0, exp_lat;
      logic [3:0] ef;
      ef      = ref_flags(xa, xb);
      exp_lat = ref_latency(xa, xb);
      @(negedge clk);
      check({tag, " in_ready"}, {in_ready, in_ready0}, 2'b11);
      a = xa;
      b = xb;
      in_valid = 1'b1;
      lat1 = 0;
      lat0 = 0;
      for (int cyc = 1; cyc <= 8 && (lat1 == 0 || lat0 == 0); cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid && lat1 == 0)  lat1 = cyc;
         if (out_valid0 && lat0 == 0) lat0 = cyc;
      end
      check({tag, " latency"}, lat1, exp_lat);
      check({tag, " latency_full"}, lat0, 3);
      check({tag, " flags"}, {unordered, equal, b_big, a_big}, ef);
      check({tag, " flags_full"}, {unordered0, equal0, b_big0, a_big0}, ef);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check({tag, " hold"}, {out_valid, out_valid0, in_ready, in_ready0,
                                unordered, equal, b_big, a_big}, {4'b1100, ef});
         if (pulse && h == 1) begin
            a = 16'h4400;
            b = 16'h3C00;
            in_valid = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " release"}, {in_ready, in_ready0, out_valid, out_valid0}, 4'b1100);
      check({tag, " flags_idle"}, {unordered, equal, b_big, a_big,
                                   unordered0, equal0, b_big0, a_big0}, 8'h00);
      if (pulse) begin
         @(negedge clk);
         check({tag, " not_queued"}, {in_ready, in_ready0, out_valid, out_valid0}, 4'b1100);
      end
   endtask

   function automatic logic [15:0] rand_pair_b(input logic [15:0] x, input int mode);
      logic [15:0] r;
      r = 16'($urandom);
      case (mode)
         1:       return x;
         2:       return x ^ 16'h8000;
         3:       return {x[15:10], r[9:0]};
         4:       return {r[15], 10'd0, r[4] ? r[4:0] : 5'd0};
         default: return r;
      endcase
   endfunction

   initial begin
      logic [15:0] ra, rb, r;
      int          mode;

      repeat (2) @(negedge clk);
      check("reset", {in_ready, out_valid, unordered, equal, b_big, a_big,
                      in_ready0, out_valid0, unordered0, equal0, b_big0, a_big0}, 12'b100000_100000);
      rst_n = 1'b1;

      run_pair(16'h3C00, 16'h4000, 0, 1'b0, "one_vs_two");
      run_pair(16'h3C01, 16'h3C00, 0, 1'b0, "mantissa");
      run_pair(16'h8000, 16'h0000, 0, 1'b0, "neg_pos_zero");
      run_pair(16'hC000, 16'hBC00, 0, 1'b0, "neg_two_neg_one");
      run_pair(16'h7E00, 16'h3C00, 0, 1'b0, "nan");
      run_pair(16'h7C00, 16'h7BFF, 0, 1'b0, "inf");
      run_pair(16'h0001, 16'h0002, 0, 1'b0, "denormal");
      run_pair(16'h3C00, 16'h4000, 5, 1'b1, "backpressure");

      // Abort a comparison while the full-length instance is in MAN.
      @(negedge clk);
      a = 16'h3C01;
      b = 16'h3C00;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_mid", {in_ready, in_ready0, out_valid, out_valid0,
                          unordered, equal, b_big, a_big,
                          unordered0, equal0, b_big0, a_big0}, 12'b1100_0000_0000);
      rst_n = 1'b1;
      run_pair(16'h3C01, 16'h3C00, 0, 1'b0, "after_reset_a");
      run_pair(16'hBC01, 16'hBC00, 0, 1'b0, "after_reset_b");

      for (int i = 0; i < 200; i++) begin
         mode = int'($urandom_range(0, 5));
         ra = 16'($urandom);
         if (mode == 4) ra = {ra[15], 15'd0};
         if (mode == 5) begin
            r  = 16'($urandom);
            ra = {ra[15], 5'h1F, r[0] ? 10'd0 : ra[9:0]};
         end
         rb = rand_pair_b(ra, mode);
         run_pair(ra, rb, int'($urandom_range(0, 2)), 1'b0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
